// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ALU, HI/LO, 32-step restoring divider,
// data-SRAM request issue and forwarding info back to decode.
module exe_stage #(
    parameter int DS_TO_ES_BUS_WD = 145,
    parameter int ES_TO_MS_BUS_WD = 71
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [4:0]                 es_to_ds_dest,
    output logic                       es_valid_r,
    output logic                       es_we_r,
    output logic [31:0]                es_fw_send,
    output logic                       es_send_ready,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_wen,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);

    logic                       r_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] r_ds_bus;
    logic [31:0]                r_hi;
    logic [31:0]                r_lo;
    logic [5:0]                 r_div_cnt;
    logic [31:0]                r_div_rem;
    logic [31:0]                r_div_quo;

    logic [19:0] w_alu_op;
    logic        w_load_op, w_src1_is_sa, w_src1_is_pc, w_src2_is_imm_0;
    logic        w_src2_is_imm, w_src2_is_8, w_gr_we, w_mem_we;
    logic [4:0]  w_dest;
    logic [15:0] w_imm;
    logic [31:0] w_rs, w_rt, w_pc;

    assign {w_alu_op, w_load_op, w_src1_is_sa, w_src1_is_pc, w_src2_is_imm_0,
            w_src2_is_imm, w_src2_is_8, w_gr_we, w_mem_we,
            w_dest, w_imm, w_rs, w_rt, w_pc} = r_ds_bus;

    logic w_div_op, w_div_signed, w_div_done, w_ready_go, w_fire, w_res_from_mem;

    assign w_div_op       = w_alu_op[18] | w_alu_op[19];
    assign w_div_signed   = w_alu_op[18];
    assign w_div_done     = (r_div_cnt == 6'd33);
    assign w_ready_go     = w_div_op ? w_div_done : 1'b1;
    assign w_fire         = r_es_valid & w_ready_go & ms_allowin;
    assign w_res_from_mem = w_load_op & ~w_mem_we;
    assign es_allowin     = ~r_es_valid | (w_ready_go & ms_allowin);

    // Pipeline valid bit and instruction bus register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_es_valid <= 1'b0;
            r_ds_bus   <= '0;
        end else if (es_allowin) begin
            r_es_valid <= ds_to_es_valid;
            if (ds_to_es_valid) begin
                r_ds_bus <= ds_to_es_bus;
            end
        end
    end

    logic [31:0] w_src1, w_src2;
    assign w_src1 = w_src1_is_sa    ? {27'd0, w_imm[10:6]} :
                    w_src1_is_pc    ? w_pc : w_rs;
    assign w_src2 = w_src2_is_imm   ? {{16{w_imm[15]}}, w_imm} :
                    w_src2_is_imm_0 ? {16'd0, w_imm} :
                    w_src2_is_8     ? 32'd8 : w_rt;

    // Divider works on magnitudes; signs are restored from the original operands.
    logic        w_dvd_neg, w_dvs_neg;
    logic [31:0] w_dvd_mag, w_dvs_mag, w_quo_fin, w_rem_fin;
    logic [32:0] w_div_shift, w_div_sub;

    assign w_dvd_neg   = w_div_signed & w_rs[31];
    assign w_dvs_neg   = w_div_signed & w_rt[31];
    assign w_dvd_mag   = w_dvd_neg ? (32'd0 - w_rs) : w_rs;
    assign w_dvs_mag   = w_dvs_neg ? (32'd0 - w_rt) : w_rt;
    assign w_div_shift = {r_div_rem, r_div_quo[31]};
    assign w_div_sub   = w_div_shift - {1'b0, w_dvs_mag};
    assign w_quo_fin   = (w_dvd_neg ^ w_dvs_neg) ? (32'd0 - r_div_quo) : r_div_quo;
    assign w_rem_fin   = w_dvd_neg ? (32'd0 - r_div_rem) : r_div_rem;

    // Divider: count 0 loads operands, counts 1..32 iterate, 33 holds the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= 6'd0;
            r_div_rem <= 32'd0;
            r_div_quo <= 32'd0;
        end else if (ds_to_es_valid & es_allowin) begin
            r_div_cnt <= 6'd0;
        end else if (r_es_valid & w_div_op & ~w_div_done) begin
            r_div_cnt <= r_div_cnt + 6'd1;
            if (r_div_cnt == 6'd0) begin
                r_div_rem <= 32'd0;
                r_div_quo <= w_dvd_mag;
            end else if (!w_div_sub[32]) begin
                r_div_rem <= w_div_sub[31:0];
                r_div_quo <= {r_div_quo[30:0], 1'b1};
            end else begin
                r_div_rem <= w_div_shift[31:0];
                r_div_quo <= {r_div_quo[30:0], 1'b0};
            end
        end
    end

    logic [63:0] w_mul_a, w_mul_b, w_prod;
    assign w_mul_a = {{32{w_alu_op[12] & w_rs[31]}}, w_rs};
    assign w_mul_b = {{32{w_alu_op[12] & w_rt[31]}}, w_rt};
    assign w_prod  = w_mul_a * w_mul_b;

    // HI/LO are written only when the owning instruction leaves ES.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_fire) begin
            if (w_alu_op[12] | w_alu_op[13]) begin
                r_hi <= w_prod[63:32];
                r_lo <= w_prod[31:0];
            end else if (w_div_op) begin
                r_hi <= w_rem_fin;
                r_lo <= w_quo_fin;
            end else if (w_alu_op[14]) begin
                r_hi <= w_rs;
            end else if (w_alu_op[15]) begin
                r_lo <= w_rs;
            end
        end
    end

    logic [31:0] w_es_result;

    // One-hot ALU result select; ops without a GPR result yield zero.
    always_comb begin
        w_es_result = 32'd0;
        case (1'b1)
            w_alu_op[0]:  w_es_result = w_src1 + w_src2;
            w_alu_op[1]:  w_es_result = w_src1 - w_src2;
            w_alu_op[2]:  w_es_result = {31'd0, ($signed(w_src1) < $signed(w_src2))};
            w_alu_op[3]:  w_es_result = {31'd0, (w_src1 < w_src2)};
            w_alu_op[4]:  w_es_result = w_src1 & w_src2;
            w_alu_op[5]:  w_es_result = ~(w_src1 | w_src2);
            w_alu_op[6]:  w_es_result = w_src1 | w_src2;
            w_alu_op[7]:  w_es_result = w_src1 ^ w_src2;
            w_alu_op[8]:  w_es_result = w_src2 << w_src1[4:0];
            w_alu_op[9]:  w_es_result = w_src2 >> w_src1[4:0];
            w_alu_op[10]: w_es_result = $unsigned($signed(w_src2) >>> w_src1[4:0]);
            w_alu_op[11]: w_es_result = {w_src2[15:0], 16'd0};
            w_alu_op[16]: w_es_result = r_hi;
            w_alu_op[17]: w_es_result = r_lo;
            default:      w_es_result = 32'd0;
        endcase
    end

    assign es_to_ms_valid  = r_es_valid & w_ready_go;
    assign es_to_ms_bus    = {w_res_from_mem, w_gr_we, w_dest, w_es_result, w_pc};
    assign es_to_ds_dest   = w_dest;
    assign es_valid_r      = r_es_valid;
    assign es_we_r         = w_gr_we;
    assign es_fw_send      = w_es_result;
    assign es_send_ready   = r_es_valid & ~w_res_from_mem & w_ready_go;
    assign data_sram_en    = r_es_valid & w_load_op & w_ready_go & ms_allowin;
    assign data_sram_wen   = {4{w_mem_we & data_sram_en}};
    assign data_sram_addr  = w_es_result;
    assign data_sram_wdata = w_rt;

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage: ALU ops, HI/LO, divider latency,
// store stall, load forwarding and mid-divide reset.
module tb_exe_stage;

    logic         clk;
    logic         reset;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [144:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic [4:0]   es_to_ds_dest;
    logic         es_valid_r;
    logic         es_we_r;
    logic [31:0]  es_fw_send;
    logic         es_send_ready;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [7:0] F_LOAD  = 8'h80;
    localparam logic [7:0] F_SA    = 8'h40;
    localparam logic [7:0] F_PC    = 8'h20;
    localparam logic [7:0] F_IMM0  = 8'h10;
    localparam logic [7:0] F_IMM   = 8'h08;
    localparam logic [7:0] F_8     = 8'h04;
    localparam logic [7:0] F_GRWE  = 8'h02;
    localparam logic [7:0] F_MEMWE = 8'h01;

    exe_stage dut (
        .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
        .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .es_to_ds_dest(es_to_ds_dest), .es_valid_r(es_valid_r), .es_we_r(es_we_r),
        .es_fw_send(es_fw_send), .es_send_ready(es_send_ready),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] op(input int n);
        logic [19:0] v;
        v = 20'd0;
        if (n >= 0) v[n] = 1'b1;
        return v;
    endfunction

    function automatic logic [144:0] mk(input logic [19:0] o, input logic [7:0] fl,
                                        input logic [4:0] d, input logic [15:0] im,
                                        input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [31:0] pc);
        return {o, fl, d, im, rs, rt, pc};
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (es_allowin !== 1'b1) begin n_err++; $display("FAIL reset_allowin: got %b exp 1", es_allowin); end
        n_cmp++;
        if (es_valid_r !== 1'b0 || es_to_ms_valid !== 1'b0 || es_we_r !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got v=%b msv=%b we=%b exp 0", es_valid_r, es_to_ms_valid, es_we_r);
        end
        n_cmp++;
        if (data_sram_en !== 1'b0 || data_sram_wen !== 4'h0) begin
            n_err++; $display("FAIL reset_sram: got en=%b wen=%h exp 0", data_sram_en, data_sram_wen);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_addiu;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(op(0), F_IMM | F_GRWE, 5'd9, 16'hFFFF, 32'd5, 32'd0, 32'h1000);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        n_cmp++;
        if (es_fw_send !== 32'd4) begin n_err++; $display("FAIL addiu_result: got %h exp 4", es_fw_send); end
        n_cmp++;
        if (es_send_ready !== 1'b1 || es_to_ms_valid !== 1'b1 || es_valid_r !== 1'b1) begin
            n_err++; $display("FAIL addiu_valid: got sr=%b msv=%b v=%b exp 1", es_send_ready, es_to_ms_valid, es_valid_r);
        end
        n_cmp++;
        if (es_to_ms_bus !== {1'b0, 1'b1, 5'd9, 32'd4, 32'h1000}) begin
            n_err++; $display("FAIL addiu_msbus: got %h", es_to_ms_bus);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu;
        logic [144:0] vb [13];
        logic [31:0]  ve [13];
        vb[0]  = mk(op(1),  F_GRWE, 5'd1, 16'h0, 32'd5, 32'd7, 32'h0);                 ve[0]  = 32'hFFFF_FFFE;
        vb[1]  = mk(op(2),  F_GRWE, 5'd1, 16'h0, 32'hFFFF_FFFF, 32'd1, 32'h0);          ve[1]  = 32'd1;
        vb[2]  = mk(op(3),  F_GRWE, 5'd1, 16'h0, 32'hFFFF_FFFF, 32'd1, 32'h0);          ve[2]  = 32'd0;
        vb[3]  = mk(op(4),  F_GRWE, 5'd1, 16'h0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0);  ve[3]  = 32'h0000_F000;
        vb[4]  = mk(op(5),  F_GRWE, 5'd1, 16'h0, 32'hF0F0_0000, 32'h0000_FFFF, 32'h0);  ve[4]  = 32'h0F0F_0000;
        vb[5]  = mk(op(6),  F_GRWE, 5'd1, 16'h0, 32'h0F, 32'hF0, 32'h0);                ve[5]  = 32'hFF;
        vb[6]  = mk(op(7),  F_GRWE, 5'd1, 16'h0, 32'hFF, 32'h0F, 32'h0);                ve[6]  = 32'hF0;
        vb[7]  = mk(op(9),  F_GRWE, 5'd1, 16'h0, 32'd4, 32'h8000_0000, 32'h0);          ve[7]  = 32'h0800_0000;
        vb[8]  = mk(op(10), F_GRWE, 5'd1, 16'h0, 32'd4, 32'h8000_0000, 32'h0);          ve[8]  = 32'hF800_0000;
        vb[9]  = mk(op(11), F_IMM | F_GRWE, 5'd1, 16'h1234, 32'd0, 32'd0, 32'h0);       ve[9]  = 32'h1234_0000;
        vb[10] = mk(op(-1), F_GRWE, 5'd1, 16'h0, 32'd5, 32'd7, 32'h0);                  ve[10] = 32'd0;
        vb[11] = mk(op(6),  F_IMM0 | F_GRWE, 5'd1, 16'h8000, 32'd0, 32'd0, 32'h0);      ve[11] = 32'h0000_8000;
        vb[12] = mk(op(0),  F_PC | F_8 | F_GRWE, 5'd31, 16'h0, 32'd0, 32'd0, 32'h400);  ve[12] = 32'h408;
        for (int i = 0; i < 13; i++) begin
            ds_to_es_valid = 1'b1;
            ds_to_es_bus   = vb[i];
            @(posedge clk); #1;
            n_cmp++;
            if (es_fw_send !== ve[i] || es_to_ms_valid !== 1'b1) begin
                n_err++; $display("FAIL alu_vec%0d: got %h msv=%b exp %h", i, es_fw_send, es_to_ms_valid, ve[i]);
            end
        end
        ds_to_es_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mult_mfhi;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(op(12), 8'h00, 5'd0, 16'h0, 32'hFFFF_FFFD, 32'd7, 32'h0);
        @(posedge clk); #1;
        ds_to_es_bus   = mk(op(16), F_GRWE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h0);
        @(posedge clk); #1;
        n_cmp++;
        if (es_fw_send !== 32'hFFFF_FFFF || es_send_ready !== 1'b1) begin
            n_err++; $display("FAIL mult_mfhi: got %h sr=%b exp ffffffff", es_fw_send, es_send_ready);
        end
        ds_to_es_bus   = mk(op(17), F_GRWE, 5'd3, 16'h0, 32'd0, 32'd0, 32'h0);
        @(posedge clk); #1;
        n_cmp++;
        if (es_fw_send !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_mflo: got %h exp ffffffeb", es_fw_send); end
        ds_to_es_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_div;
        logic [144:0] vb [2];
        logic [31:0]  elo [2];
        logic [31:0]  ehi [2];
        int n;
        vb[0] = mk(op(18), 8'h00, 5'd0, 16'h0, 32'hFFFF_FFF9, 32'd2, 32'h0); elo[0] = 32'hFFFF_FFFD; ehi[0] = 32'hFFFF_FFFF;
        vb[1] = mk(op(19), 8'h00, 5'd0, 16'h0, 32'd7, 32'd0, 32'h0);         elo[1] = 32'hFFFF_FFFF; ehi[1] = 32'd7;
        for (int i = 0; i < 2; i++) begin
            ds_to_es_valid = 1'b1;
            ds_to_es_bus   = vb[i];
            @(posedge clk); #1;
            ds_to_es_valid = 1'b0;
            n_cmp++;
            if (es_send_ready !== 1'b0 || es_allowin !== 1'b0) begin
                n_err++; $display("FAIL div%0d_busy: got sr=%b ai=%b exp 0", i, es_send_ready, es_allowin);
            end
            n = 0;
            while (es_to_ms_valid !== 1'b1 && n < 100) begin
                n++;
                @(posedge clk); #1;
            end
            n_cmp++;
            if (n != 33) begin n_err++; $display("FAIL div%0d_latency: got %0d exp 33", i, n); end
            ds_to_es_valid = 1'b1;
            ds_to_es_bus   = mk(op(17), F_GRWE, 5'd4, 16'h0, 32'd0, 32'd0, 32'h0);
            @(posedge clk); #1;
            n_cmp++;
            if (es_fw_send !== elo[i]) begin n_err++; $display("FAIL div%0d_lo: got %h exp %h", i, es_fw_send, elo[i]); end
            ds_to_es_bus   = mk(op(16), F_GRWE, 5'd5, 16'h0, 32'd0, 32'd0, 32'h0);
            @(posedge clk); #1;
            n_cmp++;
            if (es_fw_send !== ehi[i]) begin n_err++; $display("FAIL div%0d_hi: got %h exp %h", i, es_fw_send, ehi[i]); end
            ds_to_es_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_stall;
        int en_cnt;
        en_cnt         = 0;
        ms_allowin     = 1'b0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(op(0), F_LOAD | F_MEMWE | F_IMM, 5'd0, 16'h0, 32'h100, 32'hDEAD_BEEF, 32'h0);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (data_sram_en === 1'b1) en_cnt++;
            n_cmp++;
            if (data_sram_en !== 1'b0 || es_allowin !== 1'b0 || es_to_ms_valid !== 1'b1) begin
                n_err++; $display("FAIL sw_stall%0d: got en=%b ai=%b msv=%b exp 0/0/1", i, data_sram_en, es_allowin, es_to_ms_valid);
            end
            @(posedge clk); #1;
        end
        ms_allowin = 1'b1;
        #1;
        if (data_sram_en === 1'b1) en_cnt++;
        n_cmp++;
        if (data_sram_en !== 1'b1 || data_sram_wen !== 4'hF) begin
            n_err++; $display("FAIL sw_fire: got en=%b wen=%h exp 1/f", data_sram_en, data_sram_wen);
        end
        n_cmp++;
        if (data_sram_addr !== 32'h100 || data_sram_wdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL sw_addr_data: got %h/%h exp 100/deadbeef", data_sram_addr, data_sram_wdata);
        end
        @(posedge clk); #1;
        if (data_sram_en === 1'b1) en_cnt++;
        n_cmp++;
        if (en_cnt != 1) begin n_err++; $display("FAIL sw_once: got %0d requests exp 1", en_cnt); end
    endtask

    task automatic test_load_fwd;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(op(0), F_LOAD | F_IMM | F_GRWE, 5'd12, 16'h0004, 32'h200, 32'd0, 32'h0);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        n_cmp++;
        if (es_send_ready !== 1'b0 || es_we_r !== 1'b1 || es_to_ds_dest !== 5'd12) begin
            n_err++; $display("FAIL lw_fwd: got sr=%b we=%b dest=%0d exp 0/1/12", es_send_ready, es_we_r, es_to_ds_dest);
        end
        n_cmp++;
        if (data_sram_en !== 1'b1 || data_sram_wen !== 4'h0 || data_sram_addr !== 32'h204 || es_to_ms_bus[70] !== 1'b1) begin
            n_err++; $display("FAIL lw_req: got en=%b wen=%h addr=%h rfm=%b", data_sram_en, data_sram_wen, data_sram_addr, es_to_ms_bus[70]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sll;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(op(8), F_SA | F_GRWE, 5'd6, 16'h0100, 32'hFFFF_FFFF, 32'd1, 32'h0);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        n_cmp++;
        if (es_fw_send !== 32'h10 || es_send_ready !== 1'b1) begin
            n_err++; $display("FAIL sll: got %h sr=%b exp 10", es_fw_send, es_send_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_div;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(op(19), 8'h00, 5'd0, 16'h0, 32'd100, 32'd3, 32'h0);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (es_to_ms_valid !== 1'b0) begin n_err++; $display("FAIL rdiv_busy: got %b exp 0", es_to_ms_valid); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++;
        if (es_valid_r !== 1'b0 || es_allowin !== 1'b1) begin
            n_err++; $display("FAIL rdiv_valid: got v=%b ai=%b exp 0/1", es_valid_r, es_allowin);
        end
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(op(16), F_GRWE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h0);
        @(posedge clk); #1;
        n_cmp++;
        if (es_fw_send !== 32'd0) begin n_err++; $display("FAIL rdiv_hi: got %h exp 0", es_fw_send); end
        ds_to_es_bus   = mk(op(17), F_GRWE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h0);
        @(posedge clk); #1;
        n_cmp++;
        if (es_fw_send !== 32'd0) begin n_err++; $display("FAIL rdiv_lo: got %h exp 0", es_fw_send); end
        ds_to_es_bus   = mk(op(0), F_GRWE, 5'd7, 16'h0, 32'd3, 32'd4, 32'h0);
        @(posedge clk); #1;
        n_cmp++;
        if (es_fw_send !== 32'd7 || es_to_ms_valid !== 1'b1) begin
            n_err++; $display("FAIL rdiv_addu: got %h msv=%b exp 7/1", es_fw_send, es_to_ms_valid);
        end
        ds_to_es_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset          = 1'b1;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        test_reset();
        test_addiu();
        test_alu();
        test_mult_mfhi();
        test_div();
        test_store_stall();
        test_load_fwd();
        test_sll();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
